shift_reg_param: RTL

Parametrised multi-mode shift register, the next generation of the team's two-stage non-blocking shift chain. It stores DEPTH stages of WIDTH bits each and supports hold, shift toward the high stage, shift toward the low stage, rotate, and parallel load. A saturating fill counter shows how many stages hold serially inserted or loaded data. It is used as a configurable delay line and serial/parallel converter in lab datapaths.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_stage.sv | 38 +++
 rtl/shift_reg_param.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-mode shift register: mode encodings, the
// per-stage next-value select, and the occupancy counter width helper.
package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DN   = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_BELOW,
      SEL_ABOVE,
      SEL_LOAD
   } stage_sel_e;

   // Width needed to represent an occupancy of 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the shift chain with a 4-way next-value select
// (hold, from the stage below, from the stage above, parallel load).
module shift_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  stage_sel_e       sel,
   input  logic [WIDTH-1:0] below,
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q;
      unique case (sel)
         SEL_HOLD:  q_d = q;
         SEL_BELOW: q_d = below;
         SEL_ABOVE: q_d = above;
         SEL_LOAD:  q_d = load;
         default:   q_d = q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= q_d;
      end
   end

endmodule

// File: rtl/shift_reg_param.sv
// Parametrised shift register: shift up/down, rotate, parallel load, plus a
// saturating occupancy count. All outputs come straight from registers.
module shift_reg_param
   import shift_pkg::*;
#(
   parameter  int unsigned WIDTH = 1,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [1:0]             mode,
   input  logic                   rot,
   input  logic [WIDTH-1:0]       din,
   input  logic [DEPTH*WIDTH-1:0] pin,
   output logic [WIDTH-1:0]       dout_hi,
   output logic [WIDTH-1:0]       dout_lo,
   output logic [DEPTH*WIDTH-1:0] pout,
   output logic [CW-1:0]          count,
   output logic                   full
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] wrap_lo;
   logic [WIDTH-1:0] wrap_hi;
   stage_sel_e       sel;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q;

   always_comb begin
      sel = SEL_HOLD;
      if (en) begin
         unique case (mode)
            MODE_UP:   sel = SEL_BELOW;
            MODE_DN:   sel = SEL_ABOVE;
            MODE_LOAD: sel = SEL_LOAD;
            default:   sel = SEL_HOLD;
         endcase
      end
   end

   // Edge stages take either the serial input or the wrapped opposite end.
   assign wrap_lo = rot ? stage_q[DEPTH-1] : din;
   assign wrap_hi = rot ? stage_q[0] : din;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] below;
      logic [WIDTH-1:0] above;

      if (i == 0) begin : g_lo_edge
         assign below = wrap_lo;
      end else begin : g_lo_mid
         assign below = stage_q[i-1];
      end

      if (i == DEPTH - 1) begin : g_hi_edge
         assign above = wrap_hi;
      end else begin : g_hi_mid
         assign above = stage_q[i+1];
      end

      shift_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .sel  (sel),
         .below(below),
         .above(above),
         .load (pin[i*WIDTH +: WIDTH]),
         .q    (stage_q[i])
      );

      assign pout[i*WIDTH +: WIDTH] = stage_q[i];
   end

   // Occupancy since reset/load: serial inserts count, rotates do not.
   always_comb begin
      count_d = count_q;
      if (en) begin
         unique case (mode)
            MODE_UP, MODE_DN: begin
               if (!rot && (count_q != FULL_CNT)) begin
                  count_d = count_q + CW'(1);
               end
            end
            MODE_LOAD: count_d = FULL_CNT;
            default:   count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= (count_d == FULL_CNT);
      end
   end

   assign dout_hi = stage_q[DEPTH-1];
   assign dout_lo = stage_q[0];
   assign count   = count_q;
   assign full    = full_q;

endmodule
